// File: rtl/tensor_pkg.sv
// Shared types and helpers for the tensor operand dispatcher.
// The dispatcher's own widths are derived from its parameters; these are the defaults.
package tensor_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   localparam int NUM_STEPS_DEF = 4;
   localparam int NUM_WARPS_DEF = 4;
   localparam int STEPW = (NUM_STEPS_DEF > 1) ? $clog2(NUM_STEPS_DEF) : 1;
   localparam int WIDW  = (NUM_WARPS_DEF > 1) ? $clog2(NUM_WARPS_DEF) : 1;

   // Flat operand word index carried by a lane on a given beat.
   function automatic int lane_word(input int step, input int lane, input int num_mult);
      return step * num_mult + lane;
   endfunction

endpackage

// File: rtl/tensor_operand_dispatch.sv
// Buffers one tensor-op operand set and streams it to the PE as NUM_STEPS beats
// over per-lane valid/ready handshakes, then pulses completion to the scheduler.
module tensor_operand_dispatch
   import tensor_pkg::*;
#(
   parameter int NUM_MULTIPLIERS = 2,
   parameter int NUM_STEPS       = NUM_STEPS_DEF,
   parameter int NUM_WARPS       = NUM_WARPS_DEF,
   parameter int XLEN            = 32,
   localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
   localparam int WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int RD_W   = $clog2(XLEN),
   localparam int OPW    = NUM_STEPS * NUM_MULTIPLIERS * XLEN,
   localparam int LANEW  = NUM_MULTIPLIERS * XLEN
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [WID_W-1:0]           req_wid,
   input  logic [RD_W-1:0]            req_rd,
   input  logic                       req_wb,
   input  logic [OPW-1:0]             req_a,
   input  logic [OPW-1:0]             req_b,
   input  logic [OPW-1:0]             req_c,
   output logic [NUM_MULTIPLIERS-1:0] pe_valid,
   input  logic [NUM_MULTIPLIERS-1:0] pe_ready,
   output logic [LANEW-1:0]           pe_a,
   output logic [LANEW-1:0]           pe_b,
   output logic [LANEW-1:0]           pe_c,
   output logic                       pe_wb_r,
   output logic [WID_W-1:0]           pe_wid_r,
   output logic [RD_W-1:0]            pe_rd,
   output logic                       done_valid,
   output logic [WID_W-1:0]           done_wid,
   output logic                       busy
);

   state_t                     state_reg;
   logic [STEP_W-1:0]          step_reg;
   logic [NUM_MULTIPLIERS-1:0] acc_mask_reg;
   logic [WID_W-1:0]           wid_reg;
   logic [RD_W-1:0]            rd_reg;
   logic                       wb_reg;
   logic [OPW-1:0]             a_reg, b_reg, c_reg;

   logic [NUM_MULTIPLIERS-1:0] fire;
   logic                       beat_done;
   logic                       last_step;

   // pe_valid depends only on registered state, never on pe_ready.
   assign pe_valid   = {NUM_MULTIPLIERS{state_reg == ISSUE}} & ~acc_mask_reg;
   assign fire       = pe_valid & pe_ready;
   assign beat_done  = &(acc_mask_reg | fire);
   assign last_step  = (step_reg == STEP_W'(NUM_STEPS - 1));

   assign req_ready  = (state_reg == IDLE);
   assign busy       = (state_reg != IDLE);
   assign done_valid = (state_reg == DONE) & ~flush;
   assign done_wid   = wid_reg;
   assign pe_wid_r   = wid_reg;
   assign pe_rd      = rd_reg;
   assign pe_wb_r    = wb_reg & last_step & (state_reg == ISSUE);

   for (genvar gi = 0; gi < NUM_MULTIPLIERS; gi++) begin : g_lane
      assign pe_a[gi*XLEN +: XLEN] = a_reg[lane_word(int'(step_reg), gi, NUM_MULTIPLIERS)*XLEN +: XLEN];
      assign pe_b[gi*XLEN +: XLEN] = b_reg[lane_word(int'(step_reg), gi, NUM_MULTIPLIERS)*XLEN +: XLEN];
      assign pe_c[gi*XLEN +: XLEN] = c_reg[lane_word(int'(step_reg), gi, NUM_MULTIPLIERS)*XLEN +: XLEN];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= IDLE;
         step_reg     <= '0;
         acc_mask_reg <= '0;
         wid_reg      <= '0;
         rd_reg       <= '0;
         wb_reg       <= 1'b0;
         a_reg        <= '0;
         b_reg        <= '0;
         c_reg        <= '0;
      end else if (flush) begin
         state_reg    <= IDLE;
         step_reg     <= '0;
         acc_mask_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  wid_reg      <= req_wid;
                  rd_reg       <= req_rd;
                  wb_reg       <= req_wb;
                  a_reg        <= req_a;
                  b_reg        <= req_b;
                  c_reg        <= req_c;
                  step_reg     <= '0;
                  acc_mask_reg <= '0;
                  state_reg    <= ISSUE;
               end
            end
            ISSUE: begin
               if (beat_done) begin
                  acc_mask_reg <= '0;
                  if (last_step) state_reg <= DONE;
                  else           step_reg  <= step_reg + 1'b1;
               end else begin
                  acc_mask_reg <= acc_mask_reg | fire;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tensor_operand_dispatch.sv
// Directed self-checking bench for tensor_operand_dispatch (2 lanes, 4 beats, 32-bit words).
module tb_tensor_operand_dispatch;

   localparam int NM = 2;
   localparam int NS = 4;
   localparam int XL = 32;
   localparam int OPW = NS * NM * XL;

   logic            clk = 1'b0;
   logic            reset, flush, req_valid, req_ready, req_wb;
   logic [1:0]      req_wid;
   logic [4:0]      req_rd;
   logic [OPW-1:0]  req_a, req_b, req_c;
   logic [NM-1:0]   pe_valid, pe_ready;
   logic [NM*XL-1:0] pe_a, pe_b, pe_c;
   logic            pe_wb_r, done_valid, busy;
   logic [1:0]      pe_wid_r, done_wid;
   logic [4:0]      pe_rd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tensor_operand_dispatch #(.NUM_MULTIPLIERS(NM), .NUM_STEPS(NS), .NUM_WARPS(4), .XLEN(XL)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_rd(req_rd), .req_wb(req_wb),
      .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c),
      .pe_wb_r(pe_wb_r), .pe_wid_r(pe_wid_r), .pe_rd(pe_rd),
      .done_valid(done_valid), .done_wid(done_wid), .busy(busy)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_ops(input logic [31:0] base);
      for (int k = 0; k < NS*NM; k++) begin
         req_a[k*XL +: XL] = base + k;
         req_b[k*XL +: XL] = base + 32'h0100_0000 + k;
         req_c[k*XL +: XL] = base + 32'h0200_0000 + k;
      end
   endtask

   // Present one request for a single cycle; returns with beat 0 on the outputs.
   task automatic send_req(input logic [1:0] wid, input logic [4:0] rd, input logic wb, input logic [31:0] base);
      req_valid = 1'b1; req_wid = wid; req_rd = rd; req_wb = wb;
      load_ops(base);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_wid = '0; req_rd = '0; req_wb = 1'b0;
      req_a = '0; req_b = '0; req_c = '0; pe_ready = '0;
      tick(); tick();
      reset = 1'b1;
      tick();
      total++; if (pe_valid !== 2'b00) begin bad++; $display("FAIL reset_pe_valid got %b exp 00", pe_valid); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
      total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL reset_done got %b exp 0", done_valid); end
      $display("reset: pe_valid=%b req_ready=%b busy=%b", pe_valid, req_ready, busy);
   endtask

   task automatic test_stream();
      pe_ready = 2'b11;
      send_req(2'd2, 5'd5, 1'b1, 32'hA000_0000);
      for (int s = 0; s < NS; s++) begin
         total++; if (pe_valid !== 2'b11) begin bad++; $display("FAIL stream_valid beat%0d got %b exp 11", s, pe_valid); end
         total++; if (pe_a !== {32'hA000_0000 + 2*s + 1, 32'hA000_0000 + 2*s}) begin
            bad++; $display("FAIL stream_a beat%0d got %h exp %h", s, pe_a, {32'hA000_0000 + 2*s + 1, 32'hA000_0000 + 2*s}); end
         total++; if (pe_c[31:0] !== 32'hA200_0000 + 2*s) begin
            bad++; $display("FAIL stream_c beat%0d got %h exp %h", s, pe_c[31:0], 32'hA200_0000 + 2*s); end
         total++; if (pe_wb_r !== (s == NS-1)) begin bad++; $display("FAIL stream_wb beat%0d got %b exp %b", s, pe_wb_r, s == NS-1); end
         total++; if (pe_wid_r !== 2'd2 || pe_rd !== 5'd5) begin
            bad++; $display("FAIL stream_sideband beat%0d got wid=%0d rd=%0d exp wid=2 rd=5", s, pe_wid_r, pe_rd); end
         total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL stream_early_done beat%0d got 1 exp 0", s); end
         $display("stream beat%0d: valid=%b a=%h wb=%b", s, pe_valid, pe_a, pe_wb_r);
         tick();
      end
      total++; if (done_valid !== 1'b1 || done_wid !== 2'd2) begin
         bad++; $display("FAIL stream_done got v=%b wid=%0d exp v=1 wid=2", done_valid, done_wid); end
      total++; if (req_ready !== 1'b0 || pe_valid !== 2'b00) begin
         bad++; $display("FAIL stream_done_state got ready=%b valid=%b exp 0/00", req_ready, pe_valid); end
      tick();
      total++; if (req_ready !== 1'b1 || done_valid !== 1'b0) begin
         bad++; $display("FAIL stream_idle got ready=%b done=%b exp 1/0", req_ready, done_valid); end
      $display("stream done: done_wid=%0d", done_wid);
   endtask

   task automatic test_partial();
      bit seen;
      pe_ready = 2'b01;
      send_req(2'd1, 5'd3, 1'b0, 32'hA000_0000);
      total++; if (pe_valid !== 2'b11) begin bad++; $display("FAIL partial_first got %b exp 11", pe_valid); end
      tick();
      for (int c = 0; c < 2; c++) begin
         total++; if (pe_valid !== 2'b10) begin bad++; $display("FAIL partial_hold%0d got %b exp 10", c, pe_valid); end
         total++; if (pe_a[63:32] !== 32'hA000_0001) begin bad++; $display("FAIL partial_data%0d got %h exp a0000001", c, pe_a[63:32]); end
         tick();
      end
      pe_ready = 2'b10;
      total++; if (pe_valid !== 2'b10) begin bad++; $display("FAIL partial_before_fire got %b exp 10", pe_valid); end
      tick();
      total++; if (pe_valid !== 2'b11 || pe_a !== {32'hA000_0003, 32'hA000_0002}) begin
         bad++; $display("FAIL partial_next_beat got v=%b a=%h exp 11/a0000003a0000002", pe_valid, pe_a); end
      $display("partial: beat1 valid=%b a=%h", pe_valid, pe_a);
      pe_ready = 2'b11;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         tick();
         if (done_valid) seen = 1;
      end
      total++; if (!seen) begin bad++; $display("FAIL partial_done_timeout got none exp done_valid"); end
      tick();
   endtask

   task automatic test_back_to_back();
      pe_ready = 2'b11;
      send_req(2'd0, 5'd7, 1'b1, 32'hA000_0000);
      req_valid = 1'b1; req_wid = 2'd3; req_rd = 5'd9; load_ops(32'hB000_0000);
      for (int s = 0; s < NS; s++) begin
         total++; if (req_ready !== 1'b0 || pe_a[31:0] !== 32'hA000_0000 + 2*s || pe_wid_r !== 2'd0) begin
            bad++; $display("FAIL b2b_issue beat%0d got ready=%b a=%h wid=%0d exp 0/%h/0", s, req_ready, pe_a[31:0], pe_wid_r, 32'hA000_0000 + 2*s); end
         tick();
      end
      total++; if (req_ready !== 1'b0 || done_valid !== 1'b1 || done_wid !== 2'd0) begin
         bad++; $display("FAIL b2b_done got ready=%b done=%b wid=%0d exp 0/1/0", req_ready, done_valid, done_wid); end
      tick();
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got %b exp 1", req_ready); end
      tick();
      req_valid = 1'b0;
      total++; if (pe_valid !== 2'b11 || pe_a[31:0] !== 32'hB000_0000 || pe_wid_r !== 2'd3 || pe_rd !== 5'd9) begin
         bad++; $display("FAIL b2b_second got v=%b a=%h wid=%0d rd=%0d exp 11/b0000000/3/9", pe_valid, pe_a[31:0], pe_wid_r, pe_rd); end
      $display("back_to_back: second op a=%h wid=%0d", pe_a[31:0], pe_wid_r);
      for (int s = 0; s < NS; s++) tick();
      tick();
   endtask

   task automatic test_flush();
      bit seen;
      pe_ready = 2'b11;
      send_req(2'd1, 5'd2, 1'b1, 32'hC000_0000);
      tick(); tick();
      total++; if (pe_a[31:0] !== 32'hC000_0004) begin bad++; $display("FAIL flush_beat2 got %h exp c0000004", pe_a[31:0]); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (pe_valid !== 2'b00 || busy !== 1'b0) begin
         bad++; $display("FAIL flush_clear got v=%b busy=%b exp 00/0", pe_valid, busy); end
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (done_valid) seen = 1;
         tick();
      end
      total++; if (seen) begin bad++; $display("FAIL flush_no_done got done pulse exp none"); end
      send_req(2'd2, 5'd4, 1'b0, 32'hD000_0000);
      total++; if (pe_valid !== 2'b11 || pe_a !== {32'hD000_0001, 32'hD000_0000}) begin
         bad++; $display("FAIL flush_restart got v=%b a=%h exp 11/d0000001d0000000", pe_valid, pe_a); end
      $display("flush: restart a=%h", pe_a);
      for (int s = 0; s < NS; s++) tick();
      tick();
   endtask

   task automatic test_reset_midop();
      bit wb_seen, seen;
      pe_ready = 2'b11;
      send_req(2'd3, 5'd6, 1'b1, 32'hE000_0000);
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      total++; if (pe_valid !== 2'b00 || pe_a !== '0 || pe_b !== '0 || pe_wid_r !== 2'd0 || pe_rd !== 5'd0 || busy !== 1'b0 || pe_wb_r !== 1'b0) begin
         bad++; $display("FAIL midreset_clear got v=%b a=%h b=%h wid=%0d rd=%0d busy=%b wb=%b exp all 0", pe_valid, pe_a, pe_b, pe_wid_r, pe_rd, busy, pe_wb_r); end
      send_req(2'd1, 5'd1, 1'b0, 32'hF000_0000);
      wb_seen = 0;
      for (int s = 0; s < NS; s++) begin
         if (pe_wb_r) wb_seen = 1;
         total++; if (pe_a[63:32] !== 32'hF000_0001 + 2*s) begin
            bad++; $display("FAIL midreset_beat%0d got %h exp %h", s, pe_a[63:32], 32'hF000_0001 + 2*s); end
         tick();
      end
      seen = done_valid;
      total++; if (wb_seen) begin bad++; $display("FAIL midreset_wb got 1 exp 0"); end
      total++; if (!seen || done_wid !== 2'd1) begin bad++; $display("FAIL midreset_done got v=%b wid=%0d exp 1/1", seen, done_wid); end
      $display("reset_midop: wb_seen=%b done=%b", wb_seen, seen);
      tick();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_partial();
      test_back_to_back();
      test_flush();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tensor_operand_dispatch.md
Name: tensor_operand_dispatch

Overview:
- Transmitting end of the tensor PE operand-load interface. Accepts one tensor-op request per warp from the issue stage and buffers its full A/B/C operand set.
- Streams the operands to the PE as NUM_STEPS beats over per-multiplier valid/ready lanes.
- Drives wb_r/wid_r/rd side-band and signals completion to the scheduler.
- Sits between the tensor issue stage and the pe block.

Parameters:
- NUM_MULTIPLIERS, 2, PE lanes per beat
- NUM_STEPS, 4, beats per request
- NUM_WARPS, 4, warps sharing the unit
- XLEN, 32, operand word width
- Derived: STEPW = max(1, clog2(NUM_STEPS)), WIDW = max(1, clog2(NUM_WARPS)), OPW = NUM_STEPS*NUM_MULTIPLIERS*XLEN

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  synchronous abort of the op in flight
- req_valid  in  1  issue request valid
- req_ready  out  1  dispatcher can accept a request
- req_wid  in  WIDW  warp id
- req_rd  in  clog2(XLEN)  destination register or tile
- req_wb  in  1  write back to register file at end of op
- req_a / req_b / req_c  in  OPW  operand sets; word k at bits [k*XLEN +: XLEN]
- pe_valid  out  NUM_MULTIPLIERS  per-lane beat valid
- pe_ready  in  NUM_MULTIPLIERS  per-lane PE ready
- pe_a / pe_b / pe_c  out  NUM_MULTIPLIERS*XLEN  lane i word at [i*XLEN +: XLEN]
- pe_wb_r  out  1  registered wb, final beat only
- pe_wid_r  out  WIDW  registered wid
- pe_rd  out  clog2(XLEN)  registered rd
- done_valid  out  1  one-cycle completion pulse
- done_wid  out  WIDW  warp id of the completed op
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; step=0; acc_mask=0.
  - pe_valid=0, done_valid=0, pe_wb_r=0, busy=0, req_ready=1 on the next cycle.
  - All data and side-band outputs reset to 0.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: capture wid/rd/wb/a/b/c into registers; step=0; acc_mask=0; go to ISSUE.
- ISSUE:
  - req_ready=0.
  - pe_valid[i] = !acc_mask[i].
  - Lane i of beat s carries word index s*NUM_MULTIPLIERS+i of each operand set.
- Lane fire = pe_valid[i] & pe_ready[i]; acc_mask |= fire each cycle.
- A valid lane holds pe_valid and its data stable until it fires; no combinational path from pe_ready to pe_valid.
- Beat completes when (acc_mask | fire) is all ones:
  - If step < NUM_STEPS-1: step++, acc_mask=0, and the next beat is presented the following cycle.
  - Else go to DONE.
- Side-band:
  - pe_wid_r and pe_rd are constant for the whole op.
  - pe_wb_r = captured wb & (step == NUM_STEPS-1) & state==ISSUE.
- DONE:
  - done_valid=1 and done_wid=captured wid for exactly one cycle.
  - Next state IDLE; req_ready=0 in DONE.
- Latency with all lanes always ready:
  - Request accepted at edge t; beat 0 is valid in cycle t+1; beat s is valid in cycle t+1+s.
  - done_valid is high in cycle t+1+NUM_STEPS; req_ready returns in cycle t+2+NUM_STEPS.
- Partial acceptance: lanes that already fired drop pe_valid; the remaining lanes keep pe_valid; step does not advance.
- flush:
  - Flush in ISSUE or DONE goes to IDLE next cycle, clearing pe_valid, acc_mask and step.
  - No done_valid is emitted; a done pulse coinciding with flush is suppressed.
  - Flush in IDLE blocks capture that cycle.
- Reset has priority over flush, and flush over req_valid.
- Reset mid-op behaves like flush plus full register clear.
- NUM_STEPS=1: single beat, and pe_wb_r follows wb on that beat.

Decomposition:
- tensor_pkg holds:
  - state enum {IDLE, ISSUE, DONE}
  - localparams STEPW, WIDW
  - function lane_word(step, lane) returning the flat word index
- No sub-module; the operand capture is a plain register bank muxed by step.

Test Plan (NUM_MULTIPLIERS=2, NUM_STEPS=4, XLEN=32):
1. Reset held low 2 cycles, then released -> pe_valid=00, req_ready=1, busy=0, done_valid=0.
2. Request wid=2, rd=5, wb=1, A word k = 0xA000_0000+k, with pe_ready=11 -> beats in consecutive cycles with pe_a lanes (0xA0000000,0xA0000001) ... (0xA0000006,0xA0000007); pe_wb_r=1 only on beat 3; done_valid pulses 5 cycles after acceptance with done_wid=2.
3. Beat 0 with pe_ready=01 for 3 cycles, then 10 -> lane 0 fires once and drops valid; lane 1 stays valid with 0xA0000001 until it fires; beat 1 appears the cycle after.
4. req_valid asserted during ISSUE and DONE -> req_ready=0 and nothing captured; a new request is accepted in the first IDLE cycle.
5. flush asserted during beat 2 -> pe_valid=00 next cycle; no done_valid; next request restarts at beat 0.
6. reset low during beat 1, high again -> all outputs 0; a subsequent request with wb=0 runs 4 beats with pe_wb_r never asserted.
